rv_id_ex_dm: RTL and testbench

- Decode, execute and data-memory slice of the single-cycle RV32 datapath.
- Sits between the fetch stage (supplies `ins`) and the write-back mux (returns `wd`).
- Contains the register file, immediate generation, the ALU with its operand-B select, and a word-addressed data memory.
- The control signals and the write-back mux are external to this block.

---
 rtl/rv_pkg.sv | 25 ++
 rtl/rv_regfile.sv | 35 +++
 rtl/rv_id_ex_dm.sv | 89 ++++++++
 tb/tb_rv_id_ex_dm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants for the RV32 decode/execute/data-memory slice:
// ALU operation codes, major opcodes and the sign-extension helper.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [6:0] OPC_RTYPE  = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32 x 32 register file: two combinational read ports, one write port,
// synchronous active-low clear; x0 is hard-wired to zero.
module rv_regfile
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      wa,
    input  logic            we,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREGS];

    // NOTE: non-blocking assignments keep every register update aligned to the
    // edge, so same-cycle readers see the old value and no ordering race exists.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // No write bypass: a register written this cycle reads its old contents.
    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/rv_id_ex_dm.sv
// Decode, execute and data-memory slice of a single-cycle RV32 datapath:
// register file, immediate generation, ALU and word-addressed data memory.
module rv_id_ex_dm
    import rv_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = $clog2(DM_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     ins,
    input  logic [31:0]     wd,
    input  logic            RegWrite,
    input  logic            ALUSrc,
    input  logic [2:0]      op,
    input  logic            MemRead,
    input  logic            MemWrite,
    output logic [31:0]     rd1,
    output logic [31:0]     rd2,
    output logic [31:0]     imm,
    output logic [31:0]     jTarget,
    output logic [31:0]     branch,
    output logic [31:0]     z,
    output logic            zero,
    output logic [31:0]     memOut
);

    logic [31:0]      alu_b;
    logic [DM_AW-1:0] dm_idx;
    logic [31:0]      dm [DM_WORDS];

    rv_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (ins[19:15]),
        .ra2   (ins[24:20]),
        .wa    (ins[11:7]),
        .we    (RegWrite),
        .wd    (wd),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Branch offset is kept in halfwords, jump offset in words (byte LSBs dropped).
    assign branch  = {{21{ins[31]}}, ins[7], ins[30:25], ins[11:8]};
    assign jTarget = {{14{ins[31]}}, ins[19:12], ins[20], ins[30:22]};

    // NOTE: imm is given a value before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        imm = sext12(ins[31:20]);
        case (ins[6:0])
            OPC_STORE:  imm = sext12({ins[31:25], ins[11:7]});
            OPC_BRANCH: imm = branch;
            default:    imm = sext12(ins[31:20]);
        endcase
    end

    assign alu_b = ALUSrc ? imm : rd2;

    always_comb begin
        z = '0;
        case (op)
            ALU_AND: z = rd1 & alu_b;
            ALU_OR:  z = rd1 | alu_b;
            ALU_ADD: z = rd1 + alu_b;
            ALU_SUB: z = rd1 - alu_b;
            ALU_SLT: z = {31'd0, $signed(rd1) < $signed(alu_b)};
            default: z = '0;
        endcase
    end

    assign zero = (z == '0);

    // Byte address from the ALU; the low two bits are ignored and the upper
    // bits simply fall off, wrapping modulo the memory depth.
    assign dm_idx = z[DM_AW+1:2];

    // NOTE: the data memory has no reset term on purpose, so it maps onto a
    // plain RAM and keeps its contents across a register-file reset.
    always_ff @(posedge clk) begin
        if (MemWrite) begin
            dm[dm_idx] <= rd2;
        end
    end

    assign memOut = MemRead ? dm[dm_idx] : '0;

endmodule

// File: tb/tb_rv_id_ex_dm.sv
// Directed bench for rv_id_ex_dm: a behavioural model checked on every cycle
// plus hand-computed literal expectations taken from the instruction encodings.
module tb_rv_id_ex_dm;

    logic        clk;
    logic        rst_n;
    logic [31:0] ins;
    logic [31:0] wd;
    logic        RegWrite;
    logic        ALUSrc;
    logic [2:0]  op;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd1, rd2, imm, jTarget, branch, z, memOut;
    logic        zero;

    int n_cmp  = 0;
    int n_fail = 0;

    rv_id_ex_dm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins      (ins),
        .wd       (wd),
        .RegWrite (RegWrite),
        .ALUSrc   (ALUSrc),
        .op       (op),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .rd1      (rd1),
        .rd2      (rd2),
        .imm      (imm),
        .jTarget  (jTarget),
        .branch   (branch),
        .z        (z),
        .zero     (zero),
        .memOut   (memOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [int];
    bit          model_ok = 0;

    function automatic logic [31:0] m_reg(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_regs[a];
    endfunction

    function automatic int i_imm(input logic [31:0] i);
        logic signed [11:0] v;
        v = i[31:20];
        return int'(v);
    endfunction

    function automatic int s_imm(input logic [31:0] i);
        logic signed [11:0] v;
        v = {i[31:25], i[11:7]};
        return int'(v);
    endfunction

    // Full B-type byte offset, then halved.
    function automatic int b_off(input logic [31:0] i);
        logic signed [12:0] v;
        v = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        return int'(v) / 2;
    endfunction

    // Full J-type byte offset, then quartered (floor for negatives).
    function automatic int j_off(input logic [31:0] i);
        logic signed [20:0] v;
        v = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        return int'(v) >>> 2;
    endfunction

    function automatic int m_imm(input logic [31:0] i);
        if (i[6:0] == 7'h23) return s_imm(i);
        if (i[6:0] == 7'h63) return b_off(i);
        return i_imm(i);
    endfunction

    function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return 32'(sa + sb);
            3'd6:    return 32'(sa - sb);
            3'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_z();
        logic [31:0] b;
        b = ALUSrc ? 32'(m_imm(ins)) : m_reg(ins[24:20]);
        return m_alu(m_reg(ins[19:15]), b, op);
    endfunction

    function automatic int m_word(input logic [31:0] addr);
        return int'((addr / 4) % 1024);
    endfunction

    // Commit model state at each edge: memory first, using pre-edge registers.
    always @(posedge clk) begin
        logic [31:0] zz;
        zz = m_z();
        if (MemWrite) m_mem[m_word(zz)] = m_reg(ins[24:20]);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            model_ok = 1;
        end else if (RegWrite && ins[11:7] != 5'd0) begin
            m_regs[ins[11:7]] = wd;
        end
    end

    // Compare every output against the model, mid-cycle.
    always @(negedge clk) begin
        logic [31:0] ez;
        int          w;
        if (model_ok) begin
            ez = m_z();
            w  = m_word(ez);
            check("rd1", rd1, m_reg(ins[19:15]));
            check("rd2", rd2, m_reg(ins[24:20]));
            check("imm", imm, 32'(m_imm(ins)));
            check("branch", branch, 32'(b_off(ins)));
            check("jTarget", jTarget, 32'(j_off(ins)));
            check("z", z, ez);
            check("zero", {31'd0, zero}, {31'd0, ez == 32'd0});
            if (!MemRead) check("memOut_idle", memOut, 32'd0);
            else if (m_mem.exists(w)) check("memOut", memOut, m_mem[w]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic apply(input logic r, input logic [31:0] i, input logic [31:0] w,
                         input logic rw, input logic as, input logic [2:0] o,
                         input logic mr, input logic mw);
        @(posedge clk);
        #1;
        rst_n = r; ins = i; wd = w; RegWrite = rw; ALUSrc = as;
        op = o; MemRead = mr; MemWrite = mw;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ins = '0; wd = '0; RegWrite = 1'b0; ALUSrc = 1'b0;
        op = 3'd0; MemRead = 1'b0; MemWrite = 1'b0;

        apply(0, 32'h0, 0, 0, 0, 3'd0, 0, 0);
        apply(0, 32'h0, 0, 0, 0, 3'd0, 0, 0);

        // Reset state
        apply(1, 32'h006283B3, 0, 0, 0, 3'b010, 0, 0);
        check("rst_rd1", rd1, 32'd0);
        check("rst_rd2", rd2, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);

        // Load x5 = 7, x6 = 3, then add x7,x5,x6
        apply(1, 32'h00000280, 7, 1, 0, 3'b010, 0, 0);
        apply(1, 32'h00000300, 3, 1, 0, 3'b010, 0, 0);
        apply(1, 32'h006283B3, 0, 0, 0, 3'b010, 0, 0);
        check("add_rd1", rd1, 32'd7);
        check("add_rd2", rd2, 32'd3);
        check("add_z", z, 32'd10);
        check("add_zero", {31'd0, zero}, 32'd0);

        // addi x1,x0,-1 and a discarded write to x0
        apply(1, 32'hFFF00093, 0, 0, 1, 3'b010, 0, 0);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_z", z, 32'hFFFFFFFF);
        apply(1, 32'h00000013, 5, 1, 1, 3'b010, 0, 0);
        apply(1, 32'h00000033, 0, 0, 0, 3'b010, 0, 0);
        check("x0_rd1", rd1, 32'd0);

        // sw x6,8(x0) then lw 8(x0) with and without MemRead
        apply(1, 32'h00602423, 0, 0, 1, 3'b010, 0, 1);
        check("sw_imm", imm, 32'd8);
        check("sw_z", z, 32'd8);
        apply(1, 32'h00802403, 0, 0, 1, 3'b010, 1, 0);
        check("lw_mem", memOut, 32'd3);
        apply(1, 32'h00802403, 0, 0, 1, 3'b010, 0, 0);
        check("lw_noread", memOut, 32'd0);

        // Address wrap (0x1008 -> word 2) and ignored byte offset (9 -> word 2)
        apply(1, 32'h00000480, 32'h00001008, 1, 0, 3'b010, 0, 0);
        apply(1, 32'h0004A403, 0, 0, 1, 3'b010, 1, 0);
        check("wrap_mem", memOut, 32'd3);
        apply(1, 32'h00902403, 0, 0, 1, 3'b010, 1, 0);
        check("unaligned_mem", memOut, 32'd3);

        // Read and write the same word in one cycle
        apply(1, 32'h00602623, 0, 0, 1, 3'b010, 0, 1);
        apply(1, 32'h00502623, 0, 0, 1, 3'b010, 1, 1);
        check("rmw_old", memOut, 32'd3);
        apply(1, 32'h00C02403, 0, 0, 1, 3'b010, 1, 0);
        check("rmw_new", memOut, 32'd7);

        // No register bypass: x5 written with 99 while being read
        apply(1, 32'h00028280, 99, 1, 0, 3'b010, 0, 0);
        check("nobypass", rd1, 32'd7);
        apply(1, 32'h00028000, 0, 0, 0, 3'b010, 0, 0);
        check("after_wr", rd1, 32'd99);

        // beq x5,x5,-8
        apply(1, 32'hFE528CE3, 0, 0, 0, 3'b110, 0, 0);
        check("beq_z", z, 32'd0);
        check("beq_zero", {31'd0, zero}, 32'd1);
        check("beq_branch", branch, 32'hFFFFFFFC);
        check("beq_imm", imm, 32'hFFFFFFFC);

        // x11 = -2, x12 = 1; signed compare and other ALU ops
        apply(1, 32'h00000580, 32'hFFFFFFFE, 1, 0, 3'b010, 0, 0);
        apply(1, 32'h00000600, 32'd1, 1, 0, 3'b010, 0, 0);
        apply(1, 32'h00C5A6B3, 0, 0, 0, 3'b111, 0, 0);
        check("slt_lt", z, 32'd1);
        apply(1, 32'h00B626B3, 0, 0, 0, 3'b111, 0, 0);
        check("slt_ge", z, 32'd0);
        apply(1, 32'h00C5A6B3, 0, 0, 0, 3'b000, 0, 0);
        check("and", z, 32'd0);
        apply(1, 32'h00C5A6B3, 0, 0, 0, 3'b001, 0, 0);
        check("or", z, 32'hFFFFFFFF);
        apply(1, 32'h00C5A6B3, 0, 0, 0, 3'b011, 0, 0);
        check("badop", z, 32'd0);
        apply(1, 32'h00B626B3, 0, 0, 0, 3'b110, 0, 0);
        check("sub", z, 32'd3);

        // jal x1,+16
        apply(1, 32'h010000EF, 0, 0, 0, 3'b010, 0, 0);
        check("jal_jt", jTarget, 32'd4);

        // Reset coinciding with a register write (x16) and a store (x6 -> 16)
        apply(0, 32'h00602823, 123, 1, 1, 3'b010, 0, 1);
        apply(1, 32'h006283B3, 0, 0, 0, 3'b010, 0, 0);
        check("post_rst_rd1", rd1, 32'd0);
        check("post_rst_rd2", rd2, 32'd0);
        apply(1, 32'h00080000, 0, 0, 0, 3'b010, 0, 0);
        check("rst_beats_wr", rd1, 32'd0);
        apply(1, 32'h00802403, 0, 0, 1, 3'b010, 1, 0);
        check("mem_kept", memOut, 32'd3);
        apply(1, 32'h01002403, 0, 0, 1, 3'b010, 1, 0);
        check("st_in_rst", memOut, 32'd3);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
